// File: rtl/jtgng_sdram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_sdram_arb
//  Brief    : Four-port SDRAM read arbiter with a one-word hit cache per
//             requester, round-robin grant, WAIT-state watchdog and
//             refresh window signalling.
//  Options  : JTGNG_ARB_CPUPRIO_EN - requester 0 wins whenever it asks;
//             round-robin among requesters 1..3 only.
//  Revision : 1.0 - initial release
// ============================================================================
module jtgng_sdram_arb #(
    parameter int AW   = 22,
    parameter int TOUT = 63
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,

    input  logic          rq0_req,
    input  logic [AW-1:0] rq0_addr,
    output logic          rq0_ok,
    output logic [31:0]   rq0_data,

    input  logic          rq1_req,
    input  logic [AW-1:0] rq1_addr,
    output logic          rq1_ok,
    output logic [31:0]   rq1_data,

    input  logic          rq2_req,
    input  logic [AW-1:0] rq2_addr,
    output logic          rq2_ok,
    output logic [31:0]   rq2_data,

    input  logic          rq3_req,
    input  logic [AW-1:0] rq3_addr,
    output logic          rq3_ok,
    output logic [31:0]   rq3_data,

    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   data_read,

    output logic          refresh_en,
    output logic          timeout_err
);

    // Watchdog limit squeezed into the 6-bit counter width
    localparam logic [5:0] C_TOUT = 6'(TOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [1:0]    winner_q,     winner_d;
    logic [1:0]    last_q,       last_d;
    logic          sdram_req_q,  sdram_req_d;
    logic [AW-1:0] sdram_addr_q, sdram_addr_d;
    logic [5:0]    wd_q,         wd_d;
    logic          timeout_q,    timeout_d;
    logic [3:0]    ok_q,         ok_d;
    logic [3:0]    valid_q,      valid_d;
    logic [31:0]   data_q [4];
    logic [31:0]   data_d [4];
    logic [AW-1:0] tag_q  [4];
    logic [AW-1:0] tag_d  [4];

    logic [3:0]    w_req;
    logic [AW-1:0] w_addr [4];
    logic          w_pick_vld;
    logic [1:0]    w_pick;
    logic [1:0]    w_idx;
    logic          w_hit;
    logic [5:0]    w_wd_inc;

    assign w_req     = {rq3_req, rq2_req, rq1_req, rq0_req};
    assign w_addr[0] = rq0_addr;
    assign w_addr[1] = rq1_addr;
    assign w_addr[2] = rq2_addr;
    assign w_addr[3] = rq3_addr;

    // Winner selection: walk the requesters starting after the last grant
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = 2'd0;
        w_idx      = 2'd0;
`ifdef JTGNG_ARB_CPUPRIO_EN
        if (w_req[0]) begin
            w_pick_vld = 1'b1;
            w_pick     = 2'd0;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                w_idx = last_q + 2'(i);
                if (!w_pick_vld && (w_idx != 2'd0) && w_req[w_idx]) begin
                    w_pick_vld = 1'b1;
                    w_pick     = w_idx;
                end
            end
        end
`else
        for (int i = 1; i <= 4; i++) begin
            w_idx = last_q + 2'(i);
            if (!w_pick_vld && w_req[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
`endif
    end

    assign w_hit    = valid_q[w_pick] && (tag_q[w_pick] == w_addr[w_pick]);
    assign w_wd_inc = wd_q + 6'd1;

    // Next-state and datapath updates for the access sequencer
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_d       = last_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        wd_d         = 6'd0;
        timeout_d    = timeout_q;
        ok_d         = 4'd0;
        valid_d      = valid_q;
        data_d       = data_q;
        tag_d        = tag_q;

        case (state_q)
            ST_IDLE: begin
                if (!downloading && w_pick_vld) begin
                    winner_d = w_pick;
`ifdef JTGNG_ARB_CPUPRIO_EN
                    // CPU grants leave the rotation among 1..3 untouched
                    if (w_pick != 2'd0) begin
                        last_d = w_pick;
                    end
`else
                    last_d = w_pick;
`endif
                    if (w_hit) begin
                        state_d      = ST_DONE;
                        ok_d[w_pick] = 1'b1;
                    end else begin
                        state_d      = ST_REQ;
                        sdram_req_d  = 1'b1;
                        sdram_addr_d = w_addr[w_pick];
                    end
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    data_d[winner_q]  = data_read;
                    tag_d[winner_q]   = sdram_addr_q;
                    valid_d[winner_q] = 1'b1;
                    ok_d[winner_q]    = 1'b1;
                    state_d           = ST_DONE;
                end else if (w_wd_inc == C_TOUT) begin
                    // Give up; the still-held request is re-arbitrated from IDLE
                    timeout_d         = 1'b1;
                    valid_d[winner_q] = 1'b0;
                    state_d           = ST_IDLE;
                end else begin
                    wd_d = w_wd_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ROM contents are changing underneath the cache
        if (downloading) begin
            valid_d = 4'd0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            winner_q     <= 2'd0;
            last_q       <= 2'd3;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            wd_q         <= 6'd0;
            timeout_q    <= 1'b0;
            ok_q         <= 4'd0;
            valid_q      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 32'd0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_q       <= last_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            ok_q         <= ok_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
        end
    end

    assign rq0_ok      = ok_q[0];
    assign rq1_ok      = ok_q[1];
    assign rq2_ok      = ok_q[2];
    assign rq3_ok      = ok_q[3];
    assign rq0_data    = data_q[0];
    assign rq1_data    = data_q[1];
    assign rq2_data    = data_q[2];
    assign rq3_data    = data_q[3];
    assign sdram_req   = sdram_req_q;
    assign sdram_addr  = sdram_addr_q;
    assign timeout_err = timeout_q;

    // Refresh window: idle with nobody asking, or idle while a download runs
    assign refresh_en  = !rst && (state_q == ST_IDLE) && (downloading || (w_req == 4'd0));

endmodule
`default_nettype wire
